// File: rtl/eth_reply_builder.sv
// ARP / ICMP echo reply frame builder: 32-bit sop/eop/vld/rdy stream to the MAC TX,
// word 0 carries a 2-byte zero prefix. Define ETH_TX_PAD_EN to zero-pad frames through w15.
module eth_reply_builder #(
    parameter int IP_TTL    = 64,
    parameter int MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [47:0] i_self_mac,
    input  logic [31:0] i_self_ip,
    input  logic        i_arp_req_flag,
    input  logic [47:0] i_arp_req_mac,
    input  logic [31:0] i_arp_req_ip,
    output logic        o_clear_arp,
    input  logic        i_ping_req_flag,
    input  logic [47:0] i_ping_req_mac,
    input  logic [31:0] i_ping_req_ip,
    input  logic [7:0]  i_ping_size,
    input  logic [31:0] i_ping_data,
    output logic        o_ping_rd,
    output logic        o_clear_ping,
    output logic [31:0] o_tx_data,
    output logic        o_tx_sop,
    output logic        o_tx_eop,
    output logic        o_tx_vld,
    input  logic        i_tx_rdy
);

    localparam logic [7:0] TTL_B      = 8'(IP_TTL);
    localparam logic [7:0] MAX_B      = 8'(MAX_WORDS);
    localparam logic [7:0] ARP_LAST   = 8'd10;
    localparam logic [7:0] PAY_FIRST  = 8'd9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_CSUM,
        S_SEND,
        S_DONE,
        S_DROP
    } state_t;

    state_t      state_q, state_d;
    logic        sel_arp_q, sel_arp_d;
    logic [47:0] peer_mac_q, peer_mac_d;
    logic [31:0] peer_ip_q, peer_ip_d;
    logic [7:0]  size_q, size_d;
    logic [15:0] csum_q, csum_d;
    logic [7:0]  word_q, word_d;
    logic [7:0]  last_word_q, last_word_d;

    logic [15:0] total_len;
    logic [31:0] hdr_sum;
    logic [16:0] hdr_fold1;
    logic [15:0] hdr_fold2;
    logic [15:0] hdr_csum;
    logic [16:0] echo_sum;
    logic [15:0] echo_csum;
    logic [7:0]  payload_end;
    logic        in_payload;
    logic        ping_bad_size;
    logic [31:0] frame_word;

    // IPv4 header checksum; the checksum halfword itself is taken as zero
    assign total_len = 16'd20 + {6'd0, size_q, 2'b00};
    assign hdr_sum   = 32'h0000_4500 + {16'd0, total_len} + 32'h0000_4000
                     + {16'd0, TTL_B, 8'h01}
                     + {16'd0, i_self_ip[31:16]} + {16'd0, i_self_ip[15:0]}
                     + {16'd0, peer_ip_q[31:16]} + {16'd0, peer_ip_q[15:0]};
    assign hdr_fold1 = {1'b0, hdr_sum[15:0]} + {1'b0, hdr_sum[31:16]};
    assign hdr_fold2 = hdr_fold1[15:0] + {15'd0, hdr_fold1[16]};
    assign hdr_csum  = ~hdr_fold2;

    // Echo request -> reply: type drops from 8 to 0, so the checksum rises by 0x0800
    assign echo_sum  = {1'b0, i_ping_data[15:0]} + 17'h0_0800;
    assign echo_csum = echo_sum[15:0] + {15'd0, echo_sum[16]};

    assign payload_end   = 8'd8 + size_q;
    assign in_payload    = !sel_arp_q && (word_q >= PAY_FIRST) && (word_q <= payload_end);
    assign ping_bad_size = (i_ping_size < 8'd2) || (i_ping_size > MAX_B);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (i_arp_req_flag || i_ping_req_flag) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                if (!sel_arp_q && ping_bad_size) begin
                    state_d = S_DROP;
                end else begin
                    state_d = S_CSUM;
                end
            end
            S_CSUM:  state_d = S_SEND;
            S_SEND: begin
                if ((word_q == last_word_q) && i_tx_rdy) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_DROP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_tx_vld     = 1'b0;
        o_tx_sop     = 1'b0;
        o_tx_eop     = 1'b0;
        o_tx_data    = '0;
        o_ping_rd    = 1'b0;
        o_clear_arp  = 1'b0;
        o_clear_ping = 1'b0;
        case (state_q)
            S_SEND: begin
                o_tx_vld  = 1'b1;
                o_tx_sop  = (word_q == 8'd0);
                o_tx_eop  = (word_q == last_word_q);
                o_tx_data = frame_word;
                o_ping_rd = in_payload && i_tx_rdy;
            end
            S_DONE: begin
                o_clear_arp  = sel_arp_q;
                o_clear_ping = !sel_arp_q;
            end
            S_DROP:  o_clear_ping = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_arp_q   <= 1'b0;
            peer_mac_q  <= '0;
            peer_ip_q   <= '0;
            size_q      <= '0;
            csum_q      <= '0;
            word_q      <= '0;
            last_word_q <= '0;
        end else begin
            sel_arp_q   <= sel_arp_d;
            peer_mac_q  <= peer_mac_d;
            peer_ip_q   <= peer_ip_d;
            size_q      <= size_d;
            csum_q      <= csum_d;
            word_q      <= word_d;
            last_word_q <= last_word_d;
        end
    end

    always_comb begin
        sel_arp_d   = sel_arp_q;
        peer_mac_d  = peer_mac_q;
        peer_ip_d   = peer_ip_q;
        size_d      = size_q;
        csum_d      = csum_q;
        word_d      = word_q;
        last_word_d = last_word_q;
        case (state_q)
            S_IDLE: begin
                word_d = '0;
                if (i_arp_req_flag) begin
                    sel_arp_d = 1'b1;
                end else if (i_ping_req_flag) begin
                    sel_arp_d = 1'b0;
                end
            end
            S_LATCH: begin
                if (sel_arp_q) begin
                    peer_mac_d  = i_arp_req_mac;
                    peer_ip_d   = i_arp_req_ip;
                    size_d      = '0;
                    last_word_d = ARP_LAST;
                end else begin
                    peer_mac_d  = i_ping_req_mac;
                    peer_ip_d   = i_ping_req_ip;
                    size_d      = i_ping_size;
                    last_word_d = 8'd8 + i_ping_size;
                end
`ifdef ETH_TX_PAD_EN
                if (last_word_d < 8'd15) begin
                    last_word_d = 8'd15;
                end
`endif
            end
            S_CSUM:  csum_d = hdr_csum;
            S_SEND: begin
                if (i_tx_rdy) begin
                    word_d = word_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    // Frame word by index; anything past the data (pad words) reads as zero
    always_comb begin
        frame_word = '0;
        case (word_q)
            8'd0:  frame_word = {16'h0000, peer_mac_q[47:32]};
            8'd1:  frame_word = peer_mac_q[31:0];
            8'd2:  frame_word = i_self_mac[47:16];
            8'd3:  frame_word = {i_self_mac[15:0], sel_arp_q ? 16'h0806 : 16'h0800};
            8'd4:  frame_word = sel_arp_q ? 32'h0001_0800 : {8'h45, 8'h00, total_len};
            8'd5:  frame_word = sel_arp_q ? 32'h0604_0002 : 32'h0000_4000;
            8'd6:  frame_word = sel_arp_q ? i_self_mac[47:16] : {TTL_B, 8'h01, csum_q};
            8'd7:  frame_word = sel_arp_q ? {i_self_mac[15:0], i_self_ip[31:16]} : i_self_ip;
            8'd8:  frame_word = sel_arp_q ? {i_self_ip[15:0], peer_mac_q[47:32]} : peer_ip_q;
            8'd9:  frame_word = sel_arp_q ? peer_mac_q[31:0]
                                          : {8'h00, i_ping_data[23:16], echo_csum};
            8'd10: begin
                if (sel_arp_q) begin
                    frame_word = peer_ip_q;
                end else if (in_payload) begin
                    frame_word = i_ping_data;
                end
            end
            default: begin
                if (in_payload) begin
                    frame_word = i_ping_data;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_eth_reply_builder.sv
// Scoreboard bench for eth_reply_builder: expected words queued at stimulus time,
// compared on every accepted TX word; also checks stalls, pops, clears, drops and reset.
module tb_eth_reply_builder;

    localparam int MAX_WORDS = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [47:0] i_self_mac = 48'h02_00_00_00_00_01;
    logic [31:0] i_self_ip  = 32'h0A00_0002;
    logic        i_arp_req_flag = 1'b0;
    logic [47:0] i_arp_req_mac = '0;
    logic [31:0] i_arp_req_ip = '0;
    logic        o_clear_arp;
    logic        i_ping_req_flag = 1'b0;
    logic [47:0] i_ping_req_mac = '0;
    logic [31:0] i_ping_req_ip = '0;
    logic [7:0]  i_ping_size = '0;
    logic [31:0] i_ping_data = '0;
    logic        o_ping_rd;
    logic        o_clear_ping;
    logic [31:0] o_tx_data;
    logic        o_tx_sop;
    logic        o_tx_eop;
    logic        o_tx_vld;
    logic        i_tx_rdy = 1'b1;

    eth_reply_builder #(.IP_TTL(64), .MAX_WORDS(MAX_WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_self_mac(i_self_mac), .i_self_ip(i_self_ip),
        .i_arp_req_flag(i_arp_req_flag), .i_arp_req_mac(i_arp_req_mac),
        .i_arp_req_ip(i_arp_req_ip), .o_clear_arp(o_clear_arp),
        .i_ping_req_flag(i_ping_req_flag), .i_ping_req_mac(i_ping_req_mac),
        .i_ping_req_ip(i_ping_req_ip), .i_ping_size(i_ping_size),
        .i_ping_data(i_ping_data), .o_ping_rd(o_ping_rd), .o_clear_ping(o_clear_ping),
        .o_tx_data(o_tx_data), .o_tx_sop(o_tx_sop), .o_tx_eop(o_tx_eop),
        .o_tx_vld(o_tx_vld), .i_tx_rdy(i_tx_rdy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [33:0] exp_q[$];
    logic [31:0] ping_buf[$];
    int  tx_cnt = 0, n_xfer = 0, n_vld = 0, n_pops = 0;
    int  n_arp_clr = 0, n_ping_clr = 0;
    bit  stall_en = 1'b0;
    bit  pop_pending = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_csum(input logic [15:0] tl, input logic [31:0] sip,
                                             input logic [31:0] dip);
        int unsigned s;
        s = 32'h4500 + tl + 32'h4000 + 32'h4001 + sip[31:16] + sip[15:0] + dip[31:16] + dip[15:0];
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        return ~s[15:0];
    endfunction

    task automatic push_frame(input logic [31:0] w[$]);
        int n;
`ifdef ETH_TX_PAD_EN
        while (w.size() < 16) w.push_back(32'h0);
`endif
        n = w.size();
        for (int i = 0; i < n; i++) exp_q.push_back({(i == 0), (i == n - 1), w[i]});
    endtask

    task automatic push_arp_exp(input logic [47:0] rm, input logic [31:0] rip);
        logic [31:0] w[$];
        logic [47:0] sm;
        logic [31:0] sip;
        sm = i_self_mac;
        sip = i_self_ip;
        w.push_back({16'h0000, rm[47:32]});
        w.push_back(rm[31:0]);
        w.push_back(sm[47:16]);
        w.push_back({sm[15:0], 16'h0806});
        w.push_back(32'h0001_0800);
        w.push_back(32'h0604_0002);
        w.push_back(sm[47:16]);
        w.push_back({sm[15:0], sip[31:16]});
        w.push_back({sip[15:0], rm[47:32]});
        w.push_back(rm[31:0]);
        w.push_back(rip);
        push_frame(w);
    endtask

    task automatic push_ping_exp(input logic [47:0] rm, input logic [31:0] rip,
                                 input logic [31:0] pl[$]);
        logic [31:0] w[$];
        logic [47:0] sm;
        logic [15:0] tl;
        logic [16:0] e;
        logic [31:0] first;
        sm = i_self_mac;
        tl = 16'(20 + 4 * pl.size());
        first = pl[0];
        e = {1'b0, first[15:0]} + 17'h0_0800;
        w.push_back({16'h0000, rm[47:32]});
        w.push_back(rm[31:0]);
        w.push_back(sm[47:16]);
        w.push_back({sm[15:0], 16'h0800});
        w.push_back({8'h45, 8'h00, tl});
        w.push_back(32'h0000_4000);
        w.push_back({8'd64, 8'h01, ref_csum(tl, i_self_ip, rip)});
        w.push_back(i_self_ip);
        w.push_back(rip);
        w.push_back({8'h00, first[23:16], e[15:0] + {15'd0, e[16]}});
        for (int i = 1; i < pl.size(); i++) w.push_back(pl[i]);
        push_frame(w);
    endtask

    task automatic load_ping(input logic [47:0] rm, input logic [31:0] rip,
                             input logic [31:0] pl[$]);
        ping_buf = pl;
        i_ping_data = pl[0];
        i_ping_size = 8'(pl.size());
        i_ping_req_mac = rm;
        i_ping_req_ip = rip;
    endtask

    task automatic wait_clears(input int target, input int budget);
        int n = 0;
        while ((n_arp_clr + n_ping_clr) < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        #2;
        check_val("clear_total", n_arp_clr + n_ping_clr, target);
        check_val("exp_drained", exp_q.size(), 0);
    endtask

    // Sink, ping-buffer and parser model; samples 1 time unit after each falling edge
    initial begin
        logic [33:0] cur, prev_out;
        bit prev_hold;
        prev_hold = 1'b0;
        prev_out = '0;
        forever begin
            @(negedge clk);
            if (pop_pending) begin
                if (ping_buf.size() > 0) void'(ping_buf.pop_front());
                i_ping_data = (ping_buf.size() > 0) ? ping_buf[0] : 32'h0;
                pop_pending = 1'b0;
            end
            i_tx_rdy = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
            #1;
            cur = {o_tx_sop, o_tx_eop, o_tx_data};
            if (prev_hold) check_val("stall_hold", cur, prev_out);
            prev_hold = o_tx_vld && !i_tx_rdy;
            prev_out = cur;
            if (o_tx_vld) n_vld++;
            if (o_tx_vld && i_tx_rdy) begin
                n_xfer++;
                if (exp_q.size() == 0) check_val("word_expected", exp_q.size(), 1);
                else check_val("tx_word", cur, exp_q.pop_front());
                tx_cnt = o_tx_eop ? 0 : tx_cnt + 1;
            end
            if (o_ping_rd) begin
                n_pops++;
                pop_pending = 1'b1;
            end
            if (o_clear_arp) begin
                n_arp_clr++;
                i_arp_req_flag = 1'b0;
            end
            if (o_clear_ping) begin
                n_ping_clr++;
                i_ping_req_flag = 1'b0;
            end
        end
    end

    initial begin
        logic [31:0] pl[$];
        logic [47:0] req_mac;
        int base_clr, base_pops, base_arp, base_ping, base_vld, n;

        req_mac = 48'h04_11_22_33_44_55;
        repeat (3) @(negedge clk);
        #2;
        check_val("reset_outputs",
                  {o_tx_vld, o_tx_sop, o_tx_eop, o_tx_data, o_ping_rd, o_clear_arp, o_clear_ping},
                  '0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // ARP reply, with first-valid latency
        push_arp_exp(req_mac, 32'h0A00_0001);
        i_arp_req_mac = req_mac;
        i_arp_req_ip = 32'h0A00_0001;
        #3 i_arp_req_flag = 1'b1;
        @(negedge clk); #2 check_val("lat_latch_vld", o_tx_vld, 0);
        @(negedge clk); #2 check_val("lat_csum_vld", o_tx_vld, 0);
        @(negedge clk); #2 check_val("lat_send_vld", {o_tx_vld, o_tx_sop}, 2'b11);
        wait_clears(1, 200);
        check_val("arp_clear_cnt", n_arp_clr, 1);
        check_val("arp_no_ping_clear", n_ping_clr, 0);

        // Echo reply size 4 with hand-computed header words
        pl = {32'h0800_4D2A, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        load_ping(req_mac, 32'h0A00_0001, pl);
        begin
            logic [31:0] w[$];
            w = {32'h0000_0411, 32'h2233_4455, 32'h0200_0000, 32'h0001_0800,
                 32'h4500_0024, 32'h0000_4000, 32'h4001_26D7, 32'h0A00_0002,
                 32'h0A00_0001, 32'h0000_552A, 32'h1111_1111, 32'h2222_2222,
                 32'h3333_3333};
            push_frame(w);
        end
        base_pops = n_pops;
        @(negedge clk); #3 i_ping_req_flag = 1'b1;
        wait_clears(2, 200);
        check_val("ping4_pops", n_pops - base_pops, 4);
        check_val("ping4_clear_cnt", n_ping_clr, 1);

        // Same traffic under random back-pressure, plus a carry-wrapping echo checksum
        stall_en = 1'b1;
        load_ping(req_mac, 32'h0A00_0001, pl);
        push_ping_exp(req_mac, 32'h0A00_0001, pl);
        base_pops = n_pops;
        @(negedge clk); #3 i_ping_req_flag = 1'b1;
        wait_clears(3, 400);
        check_val("stall_ping4_pops", n_pops - base_pops, 4);

        pl = {32'h0800_F900};
        for (int i = 1; i < 7; i++) pl.push_back($urandom);
        load_ping(48'hAA_BB_CC_DD_EE_01, 32'hC0A8_0107, pl);
        push_ping_exp(48'hAA_BB_CC_DD_EE_01, 32'hC0A8_0107, pl);
        base_pops = n_pops;
        @(negedge clk); #3 i_ping_req_flag = 1'b1;
        wait_clears(4, 400);
        check_val("stall_ping7_pops", n_pops - base_pops, 7);

        push_arp_exp(48'h66_77_88_99_AA_BB, 32'hC0A8_0063);
        i_arp_req_mac = 48'h66_77_88_99_AA_BB;
        i_arp_req_ip = 32'hC0A8_0063;
        @(negedge clk); #3 i_arp_req_flag = 1'b1;
        wait_clears(5, 400);
        stall_en = 1'b0;

        // Both flags together: ARP first, then the echo reply
        base_arp = n_arp_clr;
        base_ping = n_ping_clr;
        base_pops = n_pops;
        pl = {32'h0800_1234, 32'hCAFE_F00D, 32'h0BAD_BEEF};
        i_arp_req_mac = req_mac;
        i_arp_req_ip = 32'h0A00_0001;
        load_ping(48'h10_20_30_40_50_60, 32'h0A00_0009, pl);
        push_arp_exp(req_mac, 32'h0A00_0001);
        push_ping_exp(48'h10_20_30_40_50_60, 32'h0A00_0009, pl);
        @(negedge clk);
        #3;
        i_arp_req_flag = 1'b1;
        i_ping_req_flag = 1'b1;
        wait_clears(7, 400);
        check_val("both_arp_clear", n_arp_clr - base_arp, 1);
        check_val("both_ping_clear", n_ping_clr - base_ping, 1);
        check_val("both_pops", n_pops - base_pops, 3);

        // Out-of-range sizes are dropped without traffic
        for (int k = 0; k < 2; k++) begin
            base_ping = n_ping_clr;
            base_pops = n_pops;
            base_vld = n_vld;
            ping_buf.delete();
            i_ping_data = 32'h0800_0000;
            i_ping_size = (k == 0) ? 8'd1 : 8'(MAX_WORDS + 1);
            @(negedge clk); #3 i_ping_req_flag = 1'b1;
            wait_clears(8 + k, 50);
            check_val("drop_clear", n_ping_clr - base_ping, 1);
            check_val("drop_pops", n_pops - base_pops, 0);
            check_val("drop_no_vld", n_vld - base_vld, 0);
        end

        // Reset while w6 of an echo reply is presented
        pl = {32'h0800_0100, 32'h5555_AAAA, 32'h7777_8888, 32'h9999_0000};
        load_ping(req_mac, 32'h0A00_0001, pl);
        push_ping_exp(req_mac, 32'h0A00_0001, pl);
        @(negedge clk); #3 i_ping_req_flag = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (!(tx_cnt == 6 && o_tx_vld) && n < 100);
        check_val("reach_w6", tx_cnt, 6);
        base_clr = n_arp_clr + n_ping_clr;
        rst_n = 1'b0;
        #1;
        check_val("reset_mid_out", {o_tx_vld, o_tx_sop, o_tx_eop, o_tx_data}, '0);
        i_ping_req_flag = 1'b0;
        exp_q.delete();
        ping_buf.delete();
        tx_cnt = 0;
        pop_pending = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        check_val("reset_no_clear", n_arp_clr + n_ping_clr, base_clr);
        rst_n = 1'b1;
        base_pops = n_pops;
        load_ping(req_mac, 32'h0A00_0001, pl);
        push_ping_exp(req_mac, 32'h0A00_0001, pl);
        @(negedge clk); #3 i_ping_req_flag = 1'b1;
        wait_clears(base_clr + 1, 200);
        check_val("post_reset_pops", n_pops - base_pops, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
